// File: rtl/serial_addac_if.sv
// Parallel-side handshake bus of the serial add/accumulate controller.
// The host starts an operation through master and collects the result.
interface serial_addac_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] operand;
    logic [1:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    modport master (
        output start, operand, op,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, operand, op,
        output busy, done, result, carry_out
    );
endinterface

// File: rtl/serial_addac_ctrl.sv
// Parallel-side controller for the bit-serial add/accumulate datapath.
// Shifts a captured operand out LSB first, gathers the returned sum bits
// (one cycle behind) plus the final carry, then pulses done.
module serial_addac_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_addac_if.slave  host,
    output logic           ser_a,
    output logic           ser_sel0,
    output logic           ser_sel1,
    output logic           ser_acc,
    output logic           ser_first,
    input  logic           ser_y,
    input  logic           ser_cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             accept;
    logic             last_bit;
    logic             busy;
    logic             done;

    assign last_bit       = (cnt == CW'(WIDTH - 1));
    assign host.busy      = busy;
    assign host.done      = done;
    assign host.result    = result_reg;
    assign host.carry_out = carry_reg;

    // Next-state and Moore outputs; serial outputs are only live in SHIFT.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        ser_a     = 1'b0;
        ser_sel0  = 1'b0;
        ser_sel1  = 1'b0;
        ser_acc   = 1'b0;
        ser_first = 1'b0;
        case (state)
            IDLE: begin
                if (host.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                ser_a     = opnd_reg[cnt];
                ser_sel0  = op_reg[0];
                ser_sel1  = op_reg[1];
                ser_acc   = 1'b1;
                ser_first = (cnt == '0);
                if (last_bit) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                // A start here chains straight into the next operation.
                if (host.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, bit counter and bit-indexed result collection.
    // ser_y lags ser_a by one cycle, so SHIFT cnt=k captures bit k-1 and
    // DRAIN captures the MSB together with the carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            opnd_reg   <= '0;
            op_reg     <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
        end else if (accept) begin
            cnt        <= '0;
            opnd_reg   <= host.operand;
            op_reg     <= host.op;
            result_reg <= '0;
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt != '0) begin
                        result_reg[cnt - CW'(1)] <= ser_y;
                    end
                    if (!last_bit) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    result_reg[WIDTH-1] <= ser_y;
                    carry_reg           <= ser_cout;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addac_ctrl.sv
// Bench for serial_addac_ctrl (WIDTH=8) with a one-cycle loopback serial unit.
module tb_serial_addac_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic ser_a, ser_sel0, ser_sel1, ser_acc, ser_first;
    logic ser_y, ser_cout;
    logic a_d = 1'b0;
    logic inv = 1'b0;
    int   tests = 0;
    int   failed = 0;

    serial_addac_if #(.WIDTH(8)) bus ();

    serial_addac_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (bus),
        .ser_a     (ser_a),
        .ser_sel0  (ser_sel0),
        .ser_sel1  (ser_sel1),
        .ser_acc   (ser_acc),
        .ser_first (ser_first),
        .ser_y     (ser_y),
        .ser_cout  (ser_cout)
    );

    always #5 clk = ~clk;

    // Loopback serial unit: y(t) = a(t-1), optionally inverted.
    always @(posedge clk) a_d <= ser_a;
    assign ser_y    = a_d ^ inv;
    assign ser_cout = a_d ^ inv;

    typedef struct {
        logic [7:0] operand;
        logic [1:0] op;
        logic       inv;
        logic [7:0] exp_result;
        logic       exp_carry;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {ser_a, ser_sel1, ser_sel0, ser_acc, ser_first, bus.busy, bus.done};
    endfunction

    // Drives start at the current negedge, then checks every cycle to done.
    task automatic go(input logic [7:0] opnd, input logic [1:0] o,
                      input logic [7:0] er, input logic ec);
        bus.start   = 1'b1;
        bus.operand = opnd;
        bus.op      = o;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start   = 1'b0;
                bus.operand = ~opnd;
                bus.op      = ~o;
            end
            if (k <= 8)
                chk("shift", 32'(outs()), 32'({opnd[k-1], o[1], o[0], 1'b1, (k == 1), 1'b1, 1'b0}));
            else if (k == 9)
                chk("drain", 32'(outs()), 32'(7'b0000010));
            else begin
                chk("done_outs", 32'(outs()), 32'(7'b0000001));
                chk("result", 32'(bus.result), 32'(er));
                chk("carry", 32'(bus.carry_out), 32'(ec));
            end
        end
    endtask

    initial begin
        vec_t vecs[5];
        int   n_done;
        int   done_k;
        logic [7:0] got_res;

        vecs[0] = '{8'hA5, 2'b10, 1'b0, 8'hA5, 1'b1};
        vecs[1] = '{8'h0F, 2'b01, 1'b1, 8'hF0, 1'b1};
        vecs[2] = '{8'h00, 2'b11, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'h5A, 2'b00, 1'b1, 8'hA5, 1'b1};
        vecs[4] = '{8'h81, 2'b01, 1'b0, 8'h81, 1'b1};

        // Reset held two cycles with start asserted.
        rst = 1'b1;
        bus.start = 1'b1;
        bus.operand = 8'hFF;
        bus.op = 2'b00;
        repeat (2) begin
            @(negedge clk);
            chk("rst_outs", 32'(outs()), 32'd0);
            chk("rst_result", 32'({bus.carry_out, bus.result}), 32'd0);
        end
        rst = 1'b0;
        go(8'hFF, 2'b00, 8'hFF, 1'b1);

        // Table vectors.
        foreach (vecs[i]) begin
            @(negedge clk);
            inv = vecs[i].inv;
            go(vecs[i].operand, vecs[i].op, vecs[i].exp_result, vecs[i].exp_carry);
        end
        inv = 1'b0;

        // Start during the third SHIFT cycle must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.operand = 8'h3C; bus.op = 2'b01;
        n_done = 0; done_k = 0; got_res = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                done_k = k;
                got_res = bus.result;
            end
            bus.start   = (k == 3);
            bus.operand = (k == 3) ? 8'hFF : 8'h3C;
        end
        chk("busy_ndone", 32'(n_done), 32'd1);
        chk("busy_done_cycle", 32'(done_k), 32'd10);
        chk("busy_result", 32'(got_res), 32'h3C);

        // Back-to-back: second start during the done cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.operand = 8'h01; bus.op = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        chk("b2b_done1", 32'(bus.done), 32'd1);
        chk("b2b_result1", 32'(bus.result), 32'h01);
        bus.start = 1'b1; bus.operand = 8'h80;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                chk("b2b_shift", 32'({ser_first, bus.busy, ser_acc}), 32'(3'b111));
                chk("b2b_cleared", 32'(bus.result), 32'd0);
            end
            chk("b2b_done2", 32'(bus.done), 32'(k == 10));
        end
        chk("b2b_result2", 32'(bus.result), 32'h80);
        chk("b2b_carry2", 32'(bus.carry_out), 32'd1);

        // Reset during SHIFT cnt=4 aborts the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.operand = 8'hAA; bus.op = 2'b11;
        n_done = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.done) n_done++;
            if (k == 1) bus.start = 1'b0;
            if (k == 5) begin
                chk("mid_partial", 32'(bus.result), 32'h02);
                rst = 1'b1;
            end
            if (k == 6) begin
                rst = 1'b0;
                chk("mid_outs", 32'(outs()), 32'd0);
                chk("mid_result", 32'(bus.result), 32'd0);
            end
        end
        chk("mid_ndone", 32'(n_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/serial_addac_ctrl.md
Name: serial_addac_ctrl

Overview:
- Parallel-side controller for the bit-serial add/accumulate datapath.
- Accepts a WIDTH-bit operand and a 2-bit operation code on a start pulse.
- Drives the operand LSB-first, one bit per clock, onto the serial interface (a, sel0, sel1, acc, first).
- Collects the returned serial sum bits (y) and the final carry (cout) into a parallel result, then pulses done.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- operand  in  WIDTH  parallel operand; captured when start is accepted.
- op  in  2  operation select; op[0] drives ser_sel0, op[1] drives ser_sel1; captured with operand.
- busy  out  1  high from the cycle after acceptance until the last result bit is captured.
- done  out  1  single-cycle pulse; result and carry_out are valid that cycle.
- result  out  WIDTH  collected serial result; holds until the next accepted start or reset.
- carry_out  out  1  ser_cout captured together with the MSB result bit.
- ser_a  out  1  serial operand bit, LSB first.
- ser_sel0  out  1  op[0] during SHIFT, else 0.
- ser_sel1  out  1  op[1] during SHIFT, else 0.
- ser_acc  out  1  accumulate enable; 1 only in SHIFT.
- ser_first  out  1  1 only on the first SHIFT cycle (bit 0); tells the serial unit to clear its carry.
- ser_y  in  1  serial result bit; valid one cycle after the corresponding ser_a bit.
- ser_cout  in  1  serial carry; valid on the same cycle as ser_y.

Behaviour:
- Reset values: every output is 0, including result and carry_out; state is IDLE and the bit counter is 0.
- Reset applied mid-operation aborts the operation; the cycle after rst deasserts is IDLE with all outputs 0.
- States: IDLE, SHIFT, DRAIN, DONE.
- IDLE:
  - start=1 loads operand/op into internal registers, clears result, sets cnt=0, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT (exactly WIDTH cycles, cnt = 0..WIDTH-1):
  - ser_a = opnd_reg[cnt], ser_acc=1, ser_sel1/ser_sel0 = op_reg, ser_first=(cnt==0), busy=1.
  - When cnt>=1, ser_y is captured into result[cnt-1].
  - cnt==WIDTH-1 moves to DRAIN; otherwise cnt increments.
- DRAIN (1 cycle):
  - All ser_* outputs are 0; busy=1.
  - ser_y is captured into result[WIDTH-1] and ser_cout into carry_out.
  - Moves to DONE.
- DONE (1 cycle):
  - done=1, busy=0, result/carry_out are stable.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation, no idle gap); otherwise the state goes to IDLE.
- Latency: start sampled in cycle N gives SHIFT in cycles N+1..N+WIDTH, DRAIN in N+WIDTH+1, and done in N+WIDTH+2.
- start while busy=1 is ignored; operand/op changes while busy do not affect the operation in flight.
- Width rule: cnt is $clog2(WIDTH) bits wide and never wraps mid-operation. The result is written bit-indexed, not shifted, so bits not yet written remain 0.
- ser_cout is ignored in every cycle except DRAIN.
- result/carry_out change only on DRAIN capture, on start acceptance (result cleared), or on reset.

Test Plan:
Unless stated, WIDTH=8 and the bench uses a loopback model where ser_y(t) = ser_a(t-1) and ser_cout(t) = ser_a(t-1).
- Reset:
  - Stimulus: hold rst=1 for 2 cycles with start=1 and operand=8'hFF.
  - Required: all outputs 0 and no done pulse; after release with start=1, done is asserted exactly 10 cycles after the start-sample cycle.
- Basic loopback:
  - Stimulus: start with operand=8'hA5, op=2'b10.
  - Required: ser_a sequence 1,0,1,0,0,1,0,1; ser_sel1=1 and ser_sel0=0 for 8 cycles; ser_first high only on the first cycle; done pulse with result=8'hA5 and carry_out=1.
- Inverting model:
  - Stimulus: bench model ser_y = ~ser_a(t-1); operand=8'h0F.
  - Required: result=8'hF0, carry_out=1 (bench ser_cout=ser_a(t-1), MSB=0 inverted).
- Busy protection:
  - Stimulus: start with operand=8'h3C, then pulse start with operand=8'hFF in the third SHIFT cycle.
  - Required: result=8'h3C and exactly one done pulse.
- Back-to-back:
  - Stimulus: first op operand=8'h01; assert start with operand=8'h80 during the done cycle.
  - Required: second SHIFT begins the next cycle; second done comes 10 cycles after the first; results are 8'h01 then 8'h80.
- Reset mid-operation:
  - Stimulus: rst=1 for 1 cycle during SHIFT cnt=4.
  - Required: the next cycle is IDLE with result=0 and busy=0, and no done pulse.
